// File: rtl/stack_alu_sequencer.sv
// Sequences one ALU instruction against the operation stack: pop operands, execute, push result.
// Optional perf counters (op_count/err_count) are built when STACK_ALU_SEQ_PERF_CNT_EN is defined.
module stack_alu_sequencer #(
  parameter int unsigned WIDTH_DATA = 32,
  parameter int unsigned DEPTH      = 32,
  localparam int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4:0]            opcode,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err_code,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [WIDTH_DATA-1:0] stk_data_in,
  input  logic [WIDTH_DATA-1:0] stk_data_out,
  input  logic [CNT_W-1:0]      stk_count,
  output logic [WIDTH_DATA-1:0] operand_a,
  output logic [WIDTH_DATA-1:0] operand_b,
  output logic [3:0]            op_alu,
  input  logic [WIDTH_DATA-1:0] result_alu,
  output logic [31:0]           op_count,
  output logic [15:0]           err_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_POP_A  = 3'd1;
  localparam logic [2:0] S_POP_B  = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_PUSH_R = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam logic [4:0] OP_FIRST = 5'd4;
  localparam logic [4:0] OP_LAST  = 5'd13;
  localparam logic [4:0] OP_DIV   = 5'd7;
  localparam logic [4:0] OP_NOT   = 5'd13;

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_UNDF = 2'd1;
  localparam logic [1:0] ERR_BADOP = 2'd2;
  localparam logic [1:0] ERR_DIV0 = 2'd3;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [4:0] opcode_q;
  logic       start_q;
  logic       accept;
  logic       op_valid;
  logic       enough;
  logic       div_zero;

  // start is a request pulse: a level held high launches only one operation
  assign accept   = (state == S_IDLE) && start && !start_q;
  assign op_valid = (opcode >= OP_FIRST) && (opcode <= OP_LAST);
  assign enough   = (opcode == OP_NOT) ? (stk_count >= CNT_W'(1)) : (stk_count >= CNT_W'(2));
  assign div_zero = (opcode_q == OP_DIV) && (operand_b == '0);

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!op_valid || !enough) state_nxt = S_ERR;
          else                      state_nxt = S_POP_A;
        end
      end
      S_POP_A:  state_nxt = (opcode_q == OP_NOT) ? S_EXEC : S_POP_B;
      S_POP_B:  state_nxt = S_EXEC;
      S_EXEC:   state_nxt = div_zero ? S_ERR : S_PUSH_R;
      S_PUSH_R: state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      S_ERR:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // state, registered strobes and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      start_q     <= 1'b0;
      opcode_q    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_code    <= ERR_OK;
      stk_push    <= 1'b0;
      stk_pop     <= 1'b0;
      stk_data_in <= '0;
      operand_a   <= '0;
      operand_b   <= '0;
      op_alu      <= '0;
    end else begin
      state    <= state_nxt;
      start_q  <= start;
      busy     <= (state_nxt != S_IDLE);
      done     <= (state_nxt == S_DONE) || (state_nxt == S_ERR);
      stk_pop  <= (state_nxt == S_POP_A) || (state_nxt == S_POP_B);
      stk_push <= (state_nxt == S_PUSH_R);
      if (accept) begin
        opcode_q <= opcode;
        op_alu   <= 4'(opcode - OP_FIRST);
        if (!op_valid)    err_code <= ERR_BADOP;
        else if (!enough) err_code <= ERR_UNDF;
        else              err_code <= ERR_OK;
        if (opcode == OP_NOT) operand_b <= '0;
      end
      case (state)
        S_POP_A: operand_a <= stk_data_out;
        S_POP_B: operand_b <= stk_data_out;
        S_EXEC: begin
          stk_data_in <= result_alu;
          if (div_zero) err_code <= ERR_DIV0;
        end
        default: ;
      endcase
    end
  end

`ifdef STACK_ALU_SEQ_PERF_CNT_EN
  // counters step together with the done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count  <= '0;
      err_count <= '0;
    end else begin
      if (state_nxt == S_DONE) op_count <= op_count + 32'd1;
      if ((state_nxt == S_ERR) && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
    end
  end
`else
  assign op_count  = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Directed bench for stack_alu_sequencer with a behavioural stack and ALU stub.
module tb_stack_alu_sequencer;
  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [4:0]       opcode;
  logic             busy, done, stk_push, stk_pop;
  logic [1:0]       err_code;
  logic [W-1:0]     stk_data_in, stk_data_out, operand_a, operand_b, result_alu;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       op_alu;
  logic [31:0]      op_count;
  logic [15:0]      err_count;

  logic             ld;
  logic [CNT_W-1:0] ld_n;
  logic [W-1:0]     ld_top, ld_second;
  logic [W-1:0]     mem [0:31];

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  stack_alu_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .busy(busy), .done(done),
    .err_code(err_code), .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
    .stk_data_out(stk_data_out), .stk_count(cnt), .operand_a(operand_a), .operand_b(operand_b),
    .op_alu(op_alu), .result_alu(result_alu), .op_count(op_count), .err_count(err_count)
  );

  // behavioural operation stack with a load port for preloading
  always @(posedge clk) begin
    if (ld) begin
      cnt    <= ld_n;
      mem[0] <= (ld_n == 6'd1) ? ld_top : ld_second;
      mem[1] <= ld_top;
    end else if (stk_pop && cnt != 6'd0) begin
      cnt <= cnt - 6'd1;
    end else if (stk_push) begin
      mem[5'(cnt)] <= stk_data_in;
      cnt          <= cnt + 6'd1;
    end
  end
  assign stk_data_out = (cnt == 6'd0) ? '0 : mem[5'(cnt - 6'd1)];

  // ALU stub
  always_comb begin
    result_alu = '0;
    case (op_alu)
      4'd0: result_alu = operand_a + operand_b;
      4'd1: result_alu = operand_a - operand_b;
      4'd2: result_alu = operand_a * operand_b;
      4'd3: result_alu = (operand_b == '0) ? '0 : operand_a / operand_b;
      4'd4: result_alu = operand_a & operand_b;
      4'd5: result_alu = ~(operand_a & operand_b);
      4'd6: result_alu = operand_a | operand_b;
      4'd7: result_alu = operand_a ^ operand_b;
      4'd8: result_alu = (operand_a == operand_b) ? '0 : ((operand_a < operand_b) ? '1 : 32'd1);
      4'd9: result_alu = ~operand_a;
      default: result_alu = '0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic preload(input logic [W-1:0] top, input logic [W-1:0] second, input int n);
    ld_top = top;
    ld_second = second;
    ld_n = CNT_W'(n);
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  typedef struct {
    logic [4:0]  opc;
    logic [31:0] top;
    logic [31:0] second;
    int          n;
    int          err;
    int          done_cyc;
    int          pops;
    int          pushes;
    int          push_cyc;
    logic [31:0] push_data;
    int          final_cnt;
  } vec_t;

  vec_t v [16];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, pops, pushes, push_cyc, done_cyc, first_pop, got_err;
    int dones;
    logic [31:0] push_data;
    logic overlap;

    v[0]  = '{5'd4,  32'd3,          32'd5,          2, 0, 5, 2, 1, 4, 32'd8,          1};
    v[1]  = '{5'd13, 32'h0000_00F0,  32'd0,          1, 0, 4, 1, 1, 3, 32'hFFFF_FF0F,  1};
    v[2]  = '{5'd5,  32'd9,          32'd0,          1, 1, 1, 0, 0, 0, 32'd0,          1};
    v[3]  = '{5'd20, 32'd1,          32'd2,          2, 2, 1, 0, 0, 0, 32'd0,          2};
    v[4]  = '{5'd7,  32'd7,          32'd0,          2, 3, 4, 2, 0, 0, 32'd0,          0};
    v[5]  = '{5'd5,  32'd10,         32'd3,          2, 0, 5, 2, 1, 4, 32'd7,          1};
    v[6]  = '{5'd9,  32'hF0F0_F0F0,  32'hFF00_FF00,  2, 0, 5, 2, 1, 4, 32'h0FFF_0FFF,  1};
    v[7]  = '{5'd12, 32'd5,          32'd9,          2, 0, 5, 2, 1, 4, 32'hFFFF_FFFF,  1};
    v[8]  = '{5'd13, 32'd0,          32'd0,          0, 1, 1, 0, 0, 0, 32'd0,          0};
    v[9]  = '{5'd3,  32'd1,          32'd2,          2, 2, 1, 0, 0, 0, 32'd0,          2};
    v[10] = '{5'd14, 32'd1,          32'd2,          2, 2, 1, 0, 0, 0, 32'd0,          2};
    v[11] = '{5'd7,  32'd20,         32'd4,          2, 0, 5, 2, 1, 4, 32'd5,          1};
    v[12] = '{5'd11, 32'h0000_00FF,  32'h0000_000F,  2, 0, 5, 2, 1, 4, 32'h0000_00F0,  1};
    v[13] = '{5'd6,  32'd6,          32'd7,          2, 0, 5, 2, 1, 4, 32'd42,         1};
    v[14] = '{5'd10, 32'h0000_0F00,  32'h0000_00F0,  2, 0, 5, 2, 1, 4, 32'h0000_0FF0,  1};
    v[15] = '{5'd8,  32'h0000_00FF,  32'h0000_003C,  2, 0, 5, 2, 1, 4, 32'h0000_003C,  1};

    ld = 1'b0; ld_n = '0; ld_top = '0; ld_second = '0; opcode = '0;
    do_reset();

    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err_code", 32'(err_code), 32'd0);
    chk("reset_strobes", 32'({stk_push, stk_pop}), 32'd0);
    chk("reset_regs", 32'(operand_a | operand_b | stk_data_in | 32'(op_alu)), 32'd0);
    chk("reset_counters", op_count | 32'(err_count), 32'd0);

    for (int i = 0; i < 16; i++) begin
      preload(v[i].top, v[i].second, v[i].n);
      opcode = v[i].opc;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1; pops = 0; pushes = 0; push_cyc = -1; done_cyc = -1; first_pop = -1;
      got_err = -1; push_data = '0; overlap = 1'b0;
      while (done_cyc < 0 && cyc <= 15) begin
        if (stk_pop) begin
          pops++;
          if (first_pop < 0) first_pop = cyc;
        end
        if (stk_push) begin
          pushes++;
          push_cyc = cyc;
          push_data = stk_data_in;
        end
        if (stk_pop && stk_push) overlap = 1'b1;
        if (done) begin
          done_cyc = cyc;
          got_err = 32'(err_code);
        end
        @(negedge clk);
        cyc++;
      end
      chk($sformatf("v%0d_done_cycle", i), done_cyc, v[i].done_cyc);
      chk($sformatf("v%0d_err_code", i), got_err, v[i].err);
      chk($sformatf("v%0d_pops", i), pops, v[i].pops);
      chk($sformatf("v%0d_pushes", i), pushes, v[i].pushes);
      chk($sformatf("v%0d_overlap", i), 32'(overlap), 32'd0);
      chk($sformatf("v%0d_final_count", i), 32'(cnt), v[i].final_cnt);
      chk($sformatf("v%0d_done_low_after", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_busy_low_after", i), 32'(busy), 32'd0);
      chk($sformatf("v%0d_op_alu", i), 32'(op_alu), 32'(4'(v[i].opc - 5'd4)));
      if (v[i].pops > 0) begin
        chk($sformatf("v%0d_first_pop", i), first_pop, 1);
        chk($sformatf("v%0d_operand_a", i), operand_a, v[i].top);
        chk($sformatf("v%0d_operand_b", i), operand_b,
            (v[i].opc == 5'd13) ? 32'd0 : v[i].second);
      end
      if (v[i].pushes > 0) begin
        chk($sformatf("v%0d_push_cycle", i), push_cyc, v[i].push_cyc);
        chk($sformatf("v%0d_push_data", i), push_data, v[i].push_data);
      end
    end

    // start held high for 10 cycles during a MUL launches exactly one operation
    do_reset();
    preload(32'd6, 32'd7, 2);
    opcode = 5'd6;
    start = 1'b1;
    dones = 0; pops = 0; pushes = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 9) start = 1'b0;
      if (done) dones++;
      if (stk_pop) pops++;
      if (stk_push) pushes++;
    end
    chk("mul_hold_dones", dones, 1);
    chk("mul_hold_pops", pops, 2);
    chk("mul_hold_pushes", pushes, 1);
    chk("mul_hold_count", 32'(cnt), 32'd1);
    chk("mul_hold_top", stk_data_out, 32'd42);
    chk("mul_hold_operands", {operand_a[15:0], operand_b[15:0]}, {16'd6, 16'd7});
    chk("mul_hold_op_alu", 32'(op_alu), 32'd2);
`ifdef STACK_ALU_SEQ_PERF_CNT_EN
    chk("mul_op_count", op_count, 32'd1);
`else
    chk("mul_op_count", op_count, 32'd0);
`endif

    // reset at cycle 2 of an ADD aborts at once
    preload(32'd1, 32'd2, 2);
    opcode = 5'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_strobes", 32'({stk_push, stk_pop}), 32'd0);
    chk("abort_operand_a", operand_a, 32'd0);
    chk("abort_counters", op_count | 32'(err_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle_after", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/stack_alu_sequencer.md
Name: stack_alu_sequencer

Overview:
- Controller that runs one ALU instruction (ADD..NOT) against the operation stack: pops operands, drives the ALU, captures the result and pushes it back.
- Sits between the cpu decode FSM and the operation stack and ALU instances.
- cpu asserts start with the opcode; the block owns the stack push/pop strobes and ALU operand/op lines until done.

Parameters:
- WIDTH_DATA, 32, data width of stack entries and ALU operands.
- DEPTH, 32, operation stack depth; CNT_W = $clog2(DEPTH)+1 (local) is the stk_count width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  request pulse, sampled only in IDLE
- opcode  in  5  cpu opcode; valid codes are ADD=4, SUB=5, MUL=6, DIV=7, AND=8, NAND=9, OR=10, XOR=11, CMP=12, NOT=13
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err_code  out  2  valid with done: 0 ok, 1 underflow, 2 bad opcode, 3 divide by zero
- stk_push  out  1  push strobe to the operation stack
- stk_pop  out  1  pop strobe to the operation stack
- stk_data_in  out  WIDTH_DATA  value to push
- stk_data_out  in  WIDTH_DATA  current top of stack, combinational; updated at the edge that applies a pop or push
- stk_count  in  CNT_W  current occupancy
- operand_a  out  WIDTH_DATA  ALU operand A (first pop, top of stack)
- operand_b  out  WIDTH_DATA  ALU operand B (second pop)
- op_alu  out  4  ALU op = opcode − 4 (ADD→0 .. NOT→9)
- result_alu  in  WIDTH_DATA  combinational ALU result
- op_count  out  32  completed-op counter (optional feature)
- err_count  out  16  error counter (optional feature)

Behaviour:
- Reset: state IDLE. All outputs are 0, including the operand, result and opcode registers. Reset mid-operation aborts immediately; operands already popped are not restored.
- States: IDLE, POP_A, POP_B, EXEC, PUSH_R, DONE, ERR.
- IDLE, start=1, latch opcode, then check in this order:
  - opcode outside 4..13 → ERR with code 2.
  - stk_count < needed (2 for binary ops, 1 for NOT) → ERR with code 1. No pop is issued.
  - otherwise → POP_A.
- POP_A: stk_pop=1; operand_a ← stk_data_out at the edge. Next state is EXEC for NOT, POP_B otherwise.
- POP_B: stk_pop=1; operand_b ← stk_data_out.
- NOT path: operand_b is held at 0.
- EXEC:
  - op_alu is driven from the latched opcode; result register ← result_alu.
  - If opcode=DIV and operand_b=0 → ERR with code 3, and no push is made (both operands are consumed).
  - Otherwise → PUSH_R.
- PUSH_R: stk_push=1, stk_data_in = result register → DONE.
- DONE: done=1, err_code=0 → IDLE.
- ERR: done=1 with the latched err_code → IDLE.
- Strobe rules:
  - stk_push and stk_pop are never high in the same cycle.
  - Each strobe is high for exactly one cycle per use.
- Latency, counting the start-accept cycle as 0:
  - Binary op: pops at cycles 1 and 2, push at 4, done at 5.
  - NOT: pop at 1, push at 3, done at 4.
  - Error detected in IDLE: done at 1.
- Signal hold rules:
  - op_alu, operand_a and operand_b hold their values from latch until the next start is accepted.
  - err_code holds until the next start is accepted.
  - done is low outside DONE and ERR.
- Start while busy is ignored, not queued.
- Full stack: after ≥1 pop a push always fits, so no overflow check is needed.
- CMP: the ALU's result is pushed unmodified.

Optional Feature:
- Macro STACK_ALU_SEQ_PERF_CNT_EN.
- Defined:
  - op_count increments on every done with err_code=0.
  - err_count increments on every done with err_code≠0 and saturates at 0xFFFF.
  - Both clear on rst.
- Undefined: both ports are tied to 0 and no counter flops are inferred.

Test Plan:
- Stack [top=3, 5], start opcode=ADD with ALU stub a+b → pops at cycles 1 and 2, stk_push with stk_data_in=8 at cycle 4, done at cycle 5, err_code=0, stk_count ends at 1.
- Stack [top=0x0000_00F0], start NOT with stub ~a → single pop, push 0xFFFF_FF0F at cycle 3, done at cycle 4, operand_b=0.
- stk_count=1, start SUB → no stk_pop ever, done at cycle 1, err_code=1, stack unchanged.
- start opcode=20 → done at cycle 1, err_code=2, no stack strobes.
- Stack [top=7, 0], start DIV → two pops, no push, done at cycle 4, err_code=3, stk_count drops by 2.
- start=1 held for 10 cycles during a MUL → exactly one operation and one done. With the macro defined: op_count=1 after the MUL; rst asserted at cycle 2 of a later op → busy=0 next cycle and both counters read 0.
